// File: rtl/muldiv_hilo.sv
// Execute-stage multiply/divide unit owning the architectural HI/LO registers.
// Multiplies and MT* commit in one cycle; divides run a 32-step restoring divider and stall E.
module muldiv_hilo #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              valid_e,
  input  logic [4:0]        alucontrol_e,
  input  logic [DATA_W-1:0] a_e,
  input  logic [DATA_W-1:0] b_e,
  input  logic              ext_stall,
  input  logic              flush_e,
  output logic              div_stall,
  output logic [DATA_W-1:0] hilo_rdata,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  localparam logic [4:0] ALU_MULT  = 5'd16;
  localparam logic [4:0] ALU_MULTU = 5'd17;
  localparam logic [4:0] ALU_DIV   = 5'd18;
  localparam logic [4:0] ALU_DIVU  = 5'd19;
  localparam logic [4:0] ALU_MTHI  = 5'd20;
  localparam logic [4:0] ALU_MTLO  = 5'd21;
  localparam logic [4:0] ALU_MFHI  = 5'd22;
  localparam logic [4:0] ALU_MFLO  = 5'd23;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]          state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   quo, rem, dvs, a_raw, q_r, r_r;
  logic                q_neg, r_neg, dvz;

  logic                is_div, is_sdiv, div_req, commit, done_commit, last_step;
  logic                sa, sb, fits;
  logic [DATA_W-1:0]   a_abs, b_abs, step_quo, step_rem, q_fin, r_fin;
  logic [DATA_W:0]     rem_sh, diff;
  logic signed [2*DATA_W-1:0] prod_s;
  logic [2*DATA_W-1:0] prod_u;

  // Control decode and pipeline handshake
  always_comb begin
    is_sdiv     = (alucontrol_e == ALU_DIV);
    is_div      = is_sdiv || (alucontrol_e == ALU_DIVU);
    div_req     = valid_e & ~flush_e & is_div;
    div_stall   = ((state == S_IDLE) & div_req) | (state == S_BUSY);
    commit      = valid_e & ~flush_e & ~ext_stall & ~div_stall;
    done_commit = (state == S_DONE) & valid_e & ~flush_e & ~ext_stall;
    last_step   = (cnt == CNT_W'(DATA_W - 1));
  end

  // Operand magnitudes, one restoring step, and final sign/zero-divisor fix-up
  always_comb begin
    sa       = is_sdiv & a_e[DATA_W-1];
    sb       = is_sdiv & b_e[DATA_W-1];
    a_abs    = sa ? -a_e : a_e;
    b_abs    = sb ? -b_e : b_e;
    rem_sh   = {rem, quo[DATA_W-1]};
    diff     = rem_sh - {1'b0, dvs};
    fits     = ~diff[DATA_W];
    step_rem = fits ? diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
    step_quo = {quo[DATA_W-2:0], fits};
    q_fin    = dvz ? '1    : (q_neg ? -step_quo : step_quo);
    r_fin    = dvz ? a_raw : (r_neg ? -step_rem : step_rem);
  end

  assign prod_s = $signed({{DATA_W{a_e[DATA_W-1]}}, a_e}) * $signed({{DATA_W{b_e[DATA_W-1]}}, b_e});
  assign prod_u = {{DATA_W{1'b0}}, a_e} * {{DATA_W{1'b0}}, b_e};

  always_comb begin
    hilo_rdata = '0;
    if (alucontrol_e == ALU_MFHI)      hilo_rdata = hi_o;
    else if (alucontrol_e == ALU_MFLO) hilo_rdata = lo_o;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (div_req) state_nxt = S_BUSY;
      S_BUSY: begin
        if (flush_e)        state_nxt = S_IDLE;
        else if (last_step) state_nxt = S_DONE;
      end
      S_DONE: if (done_commit || flush_e || !valid_e) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Divider datapath
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt   <= '0;
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      a_raw <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      dvz   <= 1'b0;
      q_r   <= '0;
      r_r   <= '0;
    end else if (state == S_IDLE && div_req) begin
      cnt   <= '0;
      quo   <= a_abs;
      rem   <= '0;
      dvs   <= b_abs;
      a_raw <= a_e;
      q_neg <= sa ^ sb;
      r_neg <= sa;
      dvz   <= (b_e == '0);
    end else if (state == S_BUSY && !flush_e) begin
      cnt <= cnt + CNT_W'(1);
      quo <= step_quo;
      rem <= step_rem;
      if (last_step) begin
        q_r <= q_fin;
        r_r <= r_fin;
      end
    end
  end

  // Architectural HI/LO, written only when the instruction leaves E
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_o <= '0;
      lo_o <= '0;
    end else if (done_commit) begin
      hi_o <= r_r;
      lo_o <= q_r;
    end else if (commit) begin
      case (alucontrol_e)
        ALU_MTHI:  hi_o <= a_e;
        ALU_MTLO:  lo_o <= a_e;
        ALU_MULT:  {hi_o, lo_o} <= prod_s;
        ALU_MULTU: {hi_o, lo_o} <= prod_u;
        default: ;
      endcase
    end
  end

endmodule
